uart_rx_oversampler: RTL and testbench



---
 rtl/uart_rx_oversampler.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
//   UART receiver fed by a 16x-oversample enable from the baud-rate generator.
//   It detects start edges, rejects short glitches, and deserialises frames
//   LSB-first. Each byte is presented with a one-cycle valid strobe, and a bad
//   stop bit raises a one-cycle framing-error strobe.
//   baud_clk is never used as a clock. It is synchronised, and its rising
//   edge becomes a one-cycle tick enable in the sysclk domain.
//
// Optional build macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is received between the data bits and
//   the stop bit, and the parity_err output is added.
//
// Ports:
//   sysclk     in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   baud_clk   in   oversample clock level (asynchronous)
//   rx         in   serial line, idle high (asynchronous)
//   rx_data    out  last good received byte
//   rx_valid   out  one-cycle pulse when rx_data updates
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high while a frame is in progress
//   parity_err out  (UART_RX_PARITY_EN only) pulses with rx_valid on mismatch
module uart_rx_oversampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic                 baud_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TICK_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // High when data plus received parity bit holds an odd number of ones.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                           input logic p);
    parity_mismatch = ^{d, p};
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  logic                 baud_meta_r, baud_sync_r, baud_prev_r, tick_r;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic                 rx_fall_s;
  state_t               state_r;
  logic [CW-1:0]        tick_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, frame_err_r, busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r, parity_err_r;
`endif

  // Two-flop synchronisers for both inputs, plus a registered baud_clk rising-edge tick.
  // The rx flops reset high so that a reset never looks like a start edge.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      baud_meta_r <= 1'b0;
      baud_sync_r <= 1'b0;
      baud_prev_r <= 1'b0;
      tick_r      <= 1'b0;
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_prev_r   <= 1'b1;
    end else begin
      baud_meta_r <= baud_clk;
      baud_sync_r <= baud_meta_r;
      baud_prev_r <= baud_sync_r;
      tick_r      <= baud_sync_r & ~baud_prev_r;
      rx_meta_r   <= rx;
      rx_sync_r   <= rx_meta_r;
      rx_prev_r   <= rx_sync_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync_r;

  // Frame FSM: counters move only on tick cycles, and strobes default low each cycle.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (rx_fall_s) begin
            state_r    <= ST_START;
            tick_cnt_r <= '0;
            busy_r     <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_r) begin
            if (tick_cnt_r == TICK_MID) begin
              if (!rx_sync_r) begin
                state_r    <= ST_DATA;
                tick_cnt_r <= '0;
                bit_cnt_r  <= '0;
              end else begin
                // A start bit that is high again at mid-bit is a line glitch.
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + CW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick_r) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= '0;
              shift_r    <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
              if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_r <= ST_PARITY;
`else
                state_r <= ST_STOP;
`endif
              end else begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + CW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_r) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= '0;
              par_bit_r  <= rx_sync_r;
              state_r    <= ST_STOP;
            end else begin
              tick_cnt_r <= tick_cnt_r + CW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick_r) begin
            if (tick_cnt_r == TICK_END) begin
              tick_cnt_r <= '0;
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              if (rx_sync_r) begin
                rx_data_r    <= shift_r;
                rx_valid_r   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_r <= parity_mismatch(shift_r, par_bit_r);
`endif
              end else begin
                frame_err_r <= 1'b1;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Testbench for uart_rx_oversampler. It uses random bytes, stop bits,
// glitch lengths and idle gaps. A frame-level model builds the expected
// event list from each transmitted frame, and a monitor builds the observed
// event list from the DUT's strobes. The two lists are compared per scenario.
module tb_uart_rx_oversampler;

  localparam int BIT_CYC = 128;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_LO = 1195 + BIT_CYC;
  localparam int LAT_HI = 1240 + BIT_CYC;
`else
  localparam int LAT_LO = 1195;
  localparam int LAT_HI = 1240;
`endif

  logic       sysclk   = 1'b0;
  logic       reset_n  = 1'b0;
  logic       baud_clk = 1'b0;
  logic       rx       = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy, parity_err;

  uart_rx_oversampler #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .baud_clk  (baud_clk),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // sysclk period 10, baud_clk period 80 (tick every 8 sysclk), offset phase
  always #5 sysclk = ~sysclk;
  initial begin
    #3;
    forever #40 baud_clk = ~baud_clk;
  end

  typedef struct {
    int     kind;   // 0 = valid byte, 1 = framing error
    int     data;
    int     perr;
    longint t;
  } ev_t;

  ev_t    obs_q[$];
  ev_t    exp_q[$];
  ev_t    mon_ev;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     both_cnt = 0;
  int     noisy_cnt = 0;
  bit     idle_watch = 1'b0;
  int     last_good = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Monitor: log every strobe seen by the DUT outputs
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (rx_valid && frame_err) both_cnt++;
      if (idle_watch && (busy || rx_valid || frame_err || parity_err)) noisy_cnt++;
      if (rx_valid) begin
        mon_ev.kind = 0; mon_ev.data = int'(rx_data);
        mon_ev.perr = int'(parity_err); mon_ev.t = cyc;
        obs_q.push_back(mon_ev);
      end
      if (frame_err) begin
        mon_ev.kind = 1; mon_ev.data = int'(rx_data);
        mon_ev.perr = int'(parity_err); mon_ev.t = cyc;
        obs_q.push_back(mon_ev);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Frame-level model: one transmitted frame yields one expected event
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop,
                             input longint t0);
    ev_t e;
    e.t = t0;
    if (stop) begin
      e.kind = 0;
      e.data = int'(b);
`ifdef UART_RX_PARITY_EN
      e.perr = int'(^{b, par});
`else
      e.perr = 0;
`endif
      last_good = int'(b);
    end else begin
      e.kind = 1;
      e.data = last_good;
      e.perr = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    model_frame(b, par, stop, cyc);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_cyc(BIT_CYC);
`endif
    rx = stop;
    wait_cyc(BIT_CYC);
  endtask

  task automatic compare_events(input string tag);
    longint d;
    check_val({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_val({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      check_val({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      check_val({tag, "_perr"}, obs_q[i].perr, exp_q[i].perr);
      d = obs_q[i].t - exp_q[i].t;
      check_val({tag, "_latency_ok"}, 32'((d >= LAT_LO) && (d <= LAT_HI)), 32'd1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       par;
    int         g;

    // Reset state
    reset_n = 1'b0;
    rx      = 1'b1;
    wait_cyc(10);
    check_val("rst_rx_data", rx_data, 32'd0);
    check_val("rst_rx_valid", rx_valid, 32'd0);
    check_val("rst_frame_err", frame_err, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    reset_n = 1'b1;

    // Quiet idle line
    idle_watch = 1'b1;
    wait_cyc(2000);
    idle_watch = 1'b0;
    check_val("idle_quiet", noisy_cnt, 32'd0);
    check_val("idle_rx_data", rx_data, 32'd0);

    // Good frame
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_cyc(300);
    compare_events("good");
    check_val("good_rx_data", rx_data, 32'hA5);

    // Glitch rejection: a fixed 24-cycle glitch, then a random-length one
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? 24 : int'($urandom_range(16, 40));
      rx = 1'b0;
      wait_cyc(g);
      check_val("glitch_busy_hi", busy, 32'd1);
      rx = 1'b1;
      wait_cyc(200);
      check_val("glitch_busy_lo", busy, 32'd0);
    end
    compare_events("glitch");

    // Framing error, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(300);
    compare_events("ferr");
    check_val("ferr_rx_data_kept", rx_data, 32'hA5);
    send_frame(8'h00, 1'b0, 1'b1);
    wait_cyc(300);
    compare_events("after_ferr");

    // Back-to-back frames with no idle gap
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    wait_cyc(300);
    if (obs_q.size() == 3) begin
      check_val("b2b_gap1_ok",
                32'(((obs_q[1].t - obs_q[0].t) >= 1270) && ((obs_q[1].t - obs_q[0].t) <= 1290)
`ifdef UART_RX_PARITY_EN
                    || (((obs_q[1].t - obs_q[0].t) >= 1398) && ((obs_q[1].t - obs_q[0].t) <= 1418))
`endif
                   ), 32'd1);
      check_val("b2b_gap2_ok",
                32'(((obs_q[2].t - obs_q[1].t) >= 1270) && ((obs_q[2].t - obs_q[1].t) <= 1290)
`ifdef UART_RX_PARITY_EN
                    || (((obs_q[2].t - obs_q[1].t) >= 1398) && ((obs_q[2].t - obs_q[1].t) <= 1418))
`endif
                   ), 32'd1);
    end
    compare_events("b2b");

    // Reset in data bit 4 of 8'h55; the transmitter abandons that frame
    b = 8'h55;
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cyc(BIT_CYC);
    end
    rx = b[4];
    wait_cyc(BIT_CYC / 2);
    check_val("abort_busy_before", busy, 32'd1);
    reset_n = 1'b0;
    wait_cyc(3);
    check_val("abort_busy_in_rst", busy, 32'd0);
    rx = 1'b1;
    reset_n = 1'b1;
    last_good = 0;
    wait_cyc(300);
    check_val("abort_rx_data", rx_data, 32'd0);
    compare_events("abort");
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_cyc(300);
    compare_events("post_reset");
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    wait_cyc(300);
    compare_events("parity_bad");
`endif

    // Randomized frames: random data, occasional bad stop or parity, random gaps
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = (^b) ^ ($urandom_range(0, 3) == 0);
      send_frame(b, par, stop);
      rx = 1'b1;
      if (!stop) wait_cyc(200);
      else       wait_cyc(int'($urandom_range(0, 200)));
    end
    wait_cyc(300);
    compare_events("rand");

    check_val("valid_err_exclusive", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
